usr_param_burst: RTL and testbench

//   Parametrised universal shift register: WIDTH-bit, 8 modes (adds rotate, arithmetic shift, clear).

---
 rtl/usr_pkg.sv | 32 +++
 rtl/usr_burst_ctrl.sv | 85 ++++++++
 rtl/usr_param_burst.sv | 110 +++++++++++
 tb/tb_usr_param_burst.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
//   Shared definitions for the universal shift register with burst engine:
//   - 3-bit mode encodings (MODE_HOLD .. MODE_CLEAR)
//   - burst FSM state enum
//   - is_shift_mode(): true for the modes a burst may run in
// ---------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } burst_state_t;

    // hold, load and clear have no meaning when repeated, so they never start a burst
    function automatic logic is_shift_mode(input logic [2:0] m);
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// usr_burst_ctrl
//   Burst FSM (IDLE/SHIFT), shift counter and mode latch.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     start        burst request
//     mode         live mode input
//     burst_len    shift count, captured on the accept edge
//     state        current FSM state (also the busy indication)
//     accept       combinational: a burst is accepted on this edge
//     done         one-cycle registered completion pulse
//     eff_mode     latched mode while shifting, live mode otherwise
//   Handshake: start is a single-cycle request; it is taken only when the FSM
//   is IDLE and mode is a shift mode. There is no backpressure; a request made
//   while SHIFT is silently ignored.
// ---------------------------------------------------------------------------
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    output burst_state_t     state,
    output logic             accept,
    output logic             done,
    output logic [2:0]       eff_mode
);

    burst_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && is_shift_mode(mode)) begin
                    accept = 1'b1;
                    mode_d = mode;
                    cnt_d  = burst_len;
                    // a zero-length burst completes immediately without shifting
                    if (burst_len != '0) state_d = ST_SHIFT;
                    else                 done_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // the edge that empties the counter performs the final shift
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state    = state_q;
    assign done     = done_q;
    assign eff_mode = (state_q == ST_SHIFT) ? mode_q : mode;

endmodule

// File: rtl/usr_param_burst.sv
// ---------------------------------------------------------------------------
// usr_param_burst
//   WIDTH-bit universal shift register with 8 modes and a burst engine that
//   repeats a shift mode burst_len times from one start command.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     mode         operation select (hold/shl/shr/load/rotl/rotr/asr/clear)
//     par_in       parallel load data
//     si           serial in
//     start        burst request; burst_len sampled on accept
//     par_out      register contents
//     so, so_valid serial out (combinational) and its qualifier
//     busy, done   burst in progress / one-cycle completion pulse
//   Build option: USR_SO_TRISTATE_EN drives so to 1'bz when so_valid=0;
//   otherwise so is 0 in that case.
// ---------------------------------------------------------------------------
module usr_param_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             si,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] par_out,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    burst_state_t     ctrl_state;
    logic             accept;
    logic [2:0]       eff_mode;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             so_bit;

    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
        .state     (ctrl_state),
        .accept    (accept),
        .done      (done),
        .eff_mode  (eff_mode)
    );

    assign busy = (ctrl_state == ST_SHIFT);

    function automatic logic [WIDTH-1:0] apply_mode(input logic [2:0]       m,
                                                    input logic [WIDTH-1:0] r,
                                                    input logic             s,
                                                    input logic [WIDTH-1:0] p);
        case (m)
            MODE_SHL:   return {r[WIDTH-2:0], s};
            MODE_SHR:   return {s, r[WIDTH-1:1]};
            MODE_LOAD:  return p;
            MODE_ROTL:  return {r[WIDTH-2:0], r[WIDTH-1]};
            MODE_ROTR:  return {r[0], r[WIDTH-1:1]};
            MODE_ASR:   return {r[WIDTH-1], r[WIDTH-1:1]};
            MODE_CLEAR: return '0;
            default:    return r;
        endcase
    endfunction

    // The accept edge only latches the burst; shifting starts on the next edge.
    // While shifting, eff_mode is the latched mode, so live inputs are ignored.
    always_comb begin
        reg_d = reg_q;
        if (!accept) reg_d = apply_mode(eff_mode, reg_q, si, par_in);
    end

    always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
    end

    assign par_out = reg_q;

    // so shows the bit that the next edge would shift out
    always_comb begin
        so_bit   = 1'b0;
        so_valid = 1'b0;
        case (eff_mode)
            MODE_SHL, MODE_ROTL: begin
                so_bit   = reg_q[WIDTH-1];
                so_valid = 1'b1;
            end
            MODE_SHR, MODE_ROTR, MODE_ASR: begin
                so_bit   = reg_q[0];
                so_valid = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef USR_SO_TRISTATE_EN
    assign so = so_valid ? so_bit : 1'bz;
`else
    assign so = so_valid ? so_bit : 1'b0;
`endif

endmodule

// File: tb/tb_usr_param_burst.sv
module tb_usr_param_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] par_in;
  logic       si;
  logic       start;
  logic [3:0] burst_len;
  logic [7:0] par_out;
  logic       so;
  logic       so_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_r;
  logic [7:0] exp_v;

`ifdef USR_SO_TRISTATE_EN
  localparam logic SO_IDLE = 1'bz;
`else
  localparam logic SO_IDLE = 1'b0;
`endif

  usr_param_burst #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .par_in    (par_in),
    .si        (si),
    .start     (start),
    .burst_len (burst_len),
    .par_out   (par_out),
    .so        (so),
    .so_valid  (so_valid),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] model_op(input logic [2:0] m, input logic [7:0] r,
                                          input logic s, input logic [7:0] p);
    case (m)
      3'd1:    return {r[6:0], s};
      3'd2:    return {s, r[7:1]};
      3'd3:    return p;
      3'd4:    return {r[6:0], r[7]};
      3'd5:    return {r[0], r[7:1]};
      3'd6:    return {r[7], r[7:1]};
      3'd7:    return 8'h00;
      default: return r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_manual(input logic [2:0] m, input logic [7:0] p, input logic s);
    mode = m; par_in = p; si = s; start = 1'b0;
    tick();
  endtask

  task automatic do_burst(input logic [2:0] m, input logic [3:0] len, input logic s,
                          input bit noise, output int bcnt, output bit got_done);
    mode = m; burst_len = len; si = s; start = 1'b1;
    tick();
    start = 1'b0; bcnt = 0; got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (noise) begin
        mode = 3'($urandom_range(0, 7));
        par_in = 8'($urandom);
        burst_len = 4'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start = 1'b0; mode = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 3'($urandom_range(0, 7)); par_in = 8'($urandom); si = 1'($urandom);
    start = 1'b1; burst_len = 4'd3;
    tick();
    tick();
    checks++; if (par_out !== 8'h00) begin errors++; $display("FAIL reset_par_out got %h exp 00", par_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst = 1'b0; start = 1'b0; mode = 3'd0;
    tick();
    model_r = 8'h00;
  endtask

  task automatic test_manual();
    drive_manual(3'd3, 8'hA5, 1'b0);
    mode = 3'd1; si = 1'b1; #1;
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL shl_so got %b exp 1", so); end
    checks++; if (so_valid !== 1'b1) begin errors++; $display("FAIL shl_so_valid got %b exp 1", so_valid); end
    exp_q.push_back(8'h4B);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (par_out !== exp_v) begin errors++; $display("FAIL shl got %h exp %h", par_out, exp_v); end

    drive_manual(3'd3, 8'h96, 1'b0);
    exp_q.push_back(8'hCB);
    drive_manual(3'd6, 8'h00, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (par_out !== exp_v) begin errors++; $display("FAIL asr got %h exp %h", par_out, exp_v); end

    drive_manual(3'd3, 8'h01, 1'b0);
    exp_q.push_back(8'h80);
    drive_manual(3'd5, 8'h00, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (par_out !== exp_v) begin errors++; $display("FAIL rotr got %h exp %h", par_out, exp_v); end

    mode = 3'd3; #1;
    checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL load_so_valid got %b exp 0", so_valid); end
    checks++; if (so !== SO_IDLE) begin errors++; $display("FAIL load_so got %b exp %b", so, SO_IDLE); end
    model_r = 8'h80;
  endtask

  task automatic test_random_manual();
    logic [2:0] m;
    logic [7:0] p;
    logic       s;
    logic       exp_so, exp_vld;
    for (int i = 0; i < 24; i++) begin
      m = 3'($urandom_range(0, 7)); p = 8'($urandom); s = 1'($urandom);
      mode = m; par_in = p; si = s; start = 1'b0; #1;
      exp_vld = (m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5 || m == 3'd6);
      exp_so = (m == 3'd1 || m == 3'd4) ? model_r[7] : model_r[0];
      checks++;
      if (so_valid !== exp_vld || (exp_vld && so !== exp_so) || (!exp_vld && so !== SO_IDLE)) begin
        errors++; $display("FAIL rand_so mode %0d got %b/%b exp %b/%b", m, so_valid, so, exp_vld, exp_so);
      end
      model_r = model_op(m, model_r, s, p);
      exp_q.push_back(model_r);
      tick();
      exp_v = exp_q.pop_front();
      checks++; if (par_out !== exp_v) begin errors++; $display("FAIL rand_manual mode %0d got %h exp %h", m, par_out, exp_v); end
    end
  endtask

  task automatic test_burst_rotl();
    int  bcnt;
    bit  got_done;
    drive_manual(3'd3, 8'hB4, 1'b0);
    exp_q.push_back(8'hA5);
    do_burst(3'd4, 4'd3, 1'b0, 1'b1, bcnt, got_done);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL rotl_burst_done_timeout got %b exp 1", got_done); end
    checks++; if (bcnt != 3) begin errors++; $display("FAIL rotl_burst_busy_cycles got %0d exp 3", bcnt); end
    exp_v = exp_q.pop_front();
    checks++; if (par_out !== exp_v) begin errors++; $display("FAIL rotl_burst got %h exp %h", par_out, exp_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rotl_burst_busy_at_done got %b exp 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rotl_done_width got %b exp 0", done); end
    model_r = 8'hA5;
  endtask

  task automatic test_zero_len();
    int  bcnt;
    bit  got_done;
    model_r = par_out === 8'hA5 ? 8'hA5 : model_r;
    do_burst(3'd1, 4'd0, 1'b1, 1'b0, bcnt, got_done);
    checks++; if (got_done !== 1'b1 || bcnt != 0) begin errors++; $display("FAIL zero_len got done %b busy %0d exp 1/0", got_done, bcnt); end
    checks++; if (par_out !== 8'hA5) begin errors++; $display("FAIL zero_len_hold got %h exp a5", par_out); end
    mode = 3'd3; par_in = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'd0;
    checks++; if (par_out !== 8'h3C) begin errors++; $display("FAIL start_load got %h exp 3c", par_out); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL start_load_ctrl got %b/%b exp 0/0", done, busy); end
  endtask

  task automatic test_back_to_back();
    int  bcnt;
    bit  got_done;
    // shr twice with si=1 from 3C, then rotr once started in the done cycle
    exp_q.push_back(8'hCF);
    exp_q.push_back(8'hE7);
    do_burst(3'd2, 4'd2, 1'b1, 1'b0, bcnt, got_done);
    exp_v = exp_q.pop_front();
    checks++; if (!got_done || par_out !== exp_v) begin errors++; $display("FAIL b2b_first got %h exp %h", par_out, exp_v); end
    do_burst(3'd5, 4'd1, 1'b0, 1'b0, bcnt, got_done);
    exp_v = exp_q.pop_front();
    checks++; if (!got_done || bcnt != 1 || par_out !== exp_v) begin errors++; $display("FAIL b2b_second got %h/%0d exp %h/1", par_out, bcnt, exp_v); end
  endtask

  task automatic test_long_burst();
    int  bcnt;
    bit  got_done;
    drive_manual(3'd3, 8'h81, 1'b0);
    exp_q.push_back(8'h03);
    do_burst(3'd4, 4'd9, 1'b0, 1'b0, bcnt, got_done);
    exp_v = exp_q.pop_front();
    checks++; if (!got_done || bcnt != 9 || par_out !== exp_v) begin errors++; $display("FAIL long_rotl got %h/%0d exp %h/9", par_out, bcnt, exp_v); end
    drive_manual(3'd3, 8'h80, 1'b0);
    exp_q.push_back(8'hFF);
    do_burst(3'd6, 4'd10, 1'b0, 1'b0, bcnt, got_done);
    exp_v = exp_q.pop_front();
    checks++; if (!got_done || par_out !== exp_v) begin errors++; $display("FAIL long_asr got %h exp %h", par_out, exp_v); end
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    drive_manual(3'd3, 8'hFF, 1'b0);
    mode = 3'd1; burst_len = 4'd5; si = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (par_out !== 8'h00) begin errors++; $display("FAIL midrst_par_out got %h exp 00", par_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_done got %0d pulses exp 0", done_seen); end
  endtask

  initial begin
    rst = 1'b1; mode = 3'd0; par_in = 8'h00; si = 1'b0; start = 1'b0; burst_len = 4'd0;
    model_r = 8'h00;
    test_reset();
    test_manual();
    test_random_manual();
    test_burst_rotl();
    test_zero_len();
    test_back_to_back();
    test_long_burst();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
